// File: rtl/ring_buffer_arbiter_if.sv
// ring_buffer_arbiter_if: requester, ring_buffer and output signals of ring_buffer_arbiter
//   req_valid_i/req_data_i/req_ready_o  per-channel request handshake, channel i data at [i*WIDTH +: WIDTH]
//   rb_rst_o/rb_enable_o/rb_data_o/rb_data_i  connection to the shared ring_buffer
//   out_valid_o/out_chan_o/out_data_o  evicted word with its owning channel
//   flush_i/busy_o  present only when RB_ARB_FLUSH_EN is defined
interface ring_buffer_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  localparam int CH_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   rb_rst_o;
  logic                   rb_enable_o;
  logic [WIDTH-1:0]       rb_data_o;
  logic [WIDTH-1:0]       rb_data_i;
  logic                   out_valid_o;
  logic [CH_W-1:0]        out_chan_o;
  logic [WIDTH-1:0]       out_data_o;
`ifdef RB_ARB_FLUSH_EN
  logic                   flush_i;
  logic                   busy_o;
  modport slave (
    input  req_valid_i, req_data_i, rb_data_i, flush_i,
    output req_ready_o, rb_rst_o, rb_enable_o, rb_data_o, out_valid_o, out_chan_o, out_data_o, busy_o
  );
  modport master (
    output req_valid_i, req_data_i, rb_data_i, flush_i,
    input  req_ready_o, rb_rst_o, rb_enable_o, rb_data_o, out_valid_o, out_chan_o, out_data_o, busy_o
  );
`else
  modport slave (
    input  req_valid_i, req_data_i, rb_data_i,
    output req_ready_o, rb_rst_o, rb_enable_o, rb_data_o, out_valid_o, out_chan_o, out_data_o
  );
  modport master (
    output req_valid_i, req_data_i, rb_data_i,
    input  req_ready_o, rb_rst_o, rb_enable_o, rb_data_o, out_valid_o, out_chan_o, out_data_o
  );
`endif
endinterface

// File: rtl/ring_buffer_arbiter.sv
// ring_buffer_arbiter: round-robin sharing of one ring_buffer delay line, with a tag ring naming each evicted word's channel
//   clk_i  clock; rst_ni  asynchronous active-low reset
//   bus    ring_buffer_arbiter_if.slave (requesters, ring_buffer connection, evicted-word output)
//   Optional flush state enabled by defining RB_ARB_FLUSH_EN (adds bus.flush_i / bus.busy_o)
module ring_buffer_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int N_REQ = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  ring_buffer_arbiter_if.slave bus
);
  localparam int CH_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int PW   = $clog2(DEPTH);
  logic [DEPTH-1:0]           tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][CH_W-1:0] tag_ch_q, tag_ch_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [CH_W-1:0]            prio_q, prio_d, out_chan_q, out_chan_d, gnt_ch, idx;
  logic [WIDTH-1:0]           out_data_q, out_data_d, wdata;
  logic [N_REQ-1:0]           gnt;
  logic                       rb_rst_q, out_valid_q, out_valid_d, gnt_any, en, flushing;
`ifdef RB_ARB_FLUSH_EN
  typedef enum logic {ARB, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  assign flushing   = state_q == FLUSH;
  assign bus.busy_o = flushing;
  always_comb begin
    state_d = flushing ? (cnt_q == PW'(DEPTH-1) ? ARB : FLUSH) : (bus.flush_i && |tag_vld_q ? FLUSH : ARB);
    cnt_d   = flushing ? cnt_q + 1'b1 : '0;
  end
`else
  assign flushing = 1'b0;
`endif
  // Rotating search from prio_q; rb_rst_q holds off grants so the buffer ptr and tag ptr leave reset together.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = CH_W'((32'(prio_q) + i) % N_REQ);
      if (!gnt_any && !rb_rst_q && !flushing && bus.req_valid_i[idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = idx;
      end
    end
    gnt   = gnt_any ? N_REQ'(1) << gnt_ch : '0;
    wdata = gnt_any ? bus.req_data_i[gnt_ch*WIDTH +: WIDTH] : '0;
    en    = gnt_any | flushing;
  end
  // A flush enable writes an invalid tag, so flushed slots never produce output later.
  always_comb begin
    tag_vld_d   = tag_vld_q;
    tag_ch_d    = tag_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = en && tag_vld_q[ptr_q];
    out_chan_d  = out_valid_d ? tag_ch_q[ptr_q] : out_chan_q;
    out_data_d  = out_valid_d ? bus.rb_data_i : out_data_q;
    prio_d      = gnt_any ? (gnt_ch == CH_W'(N_REQ-1) ? '0 : gnt_ch + 1'b1) : prio_q;
    if (en) begin
      tag_vld_d[ptr_q] = gnt_any;
      tag_ch_d[ptr_q]  = gnt_ch;
      ptr_d            = ptr_q == PW'(DEPTH-1) ? '0 : ptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rb_rst_q    <= 1'b1;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      ptr_q       <= '0;
      prio_q      <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
`ifdef RB_ARB_FLUSH_EN
      state_q     <= ARB;
      cnt_q       <= '0;
`endif
    end else begin
      rb_rst_q    <= 1'b0;
      tag_vld_q   <= tag_vld_d;
      tag_ch_q    <= tag_ch_d;
      ptr_q       <= ptr_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
`ifdef RB_ARB_FLUSH_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`endif
    end
  end
  assign bus.req_ready_o = gnt;
  assign bus.rb_rst_o    = rb_rst_q;
  assign bus.rb_enable_o = en;
  assign bus.rb_data_o   = wdata;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_chan_o  = out_chan_q;
  assign bus.out_data_o  = out_data_q;
endmodule

// File: tb/tb_ring_buffer_arbiter.sv
// tb_ring_buffer_arbiter: directed table-driven bench for ring_buffer_arbiter with a behavioural ring_buffer
module tb_ring_buffer_arbiter;
  typedef struct {
    logic [3:0] v;
    logic [3:0] r;
  } vec_t;
  logic clk_i = 1'b0;
  logic rst_ni;
  int total = 0;
  int bad = 0;
  logic [9:0] sbq[$];
  logic exp_ov;
  logic [1:0] exp_ch;
  logic [7:0] exp_d, fw;
  logic [5:0] seq = '0;
  logic [7:0] rb_mem[8];
  logic [2:0] rb_ptr;
  vec_t fair_tbl[$];
  vec_t mix_tbl[$];
  ring_buffer_arbiter_if #(.WIDTH(8), .N_REQ(4)) bus();
  ring_buffer_arbiter #(.WIDTH(8), .DEPTH(8), .N_REQ(4)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  always #5 clk_i = ~clk_i;
  assign bus.rb_data_i = rb_mem[rb_ptr];
  always @(posedge clk_i) begin
    if (bus.rb_rst_o) begin
      rb_ptr <= '0;
      for (int i = 0; i < 8; i++) rb_mem[i] <= '0;
    end else if (bus.rb_enable_o) begin
      rb_mem[rb_ptr] <= bus.rb_data_o;
      rb_ptr <= rb_ptr + 3'd1;
    end
  end
  function automatic logic [31:0] mkd(input logic [5:0] s);
    return {2'd3, s, 2'd2, s, 2'd1, s, 2'd0, s};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic [3:0] v, input logic [3:0] er, input logic [31:0] d);
    logic [1:0] gc;
    logic [7:0] gd;
    bus.req_valid_i = v;
    bus.req_data_i = d;
    #4;
    gc = er[1] ? 2'd1 : er[2] ? 2'd2 : er[3] ? 2'd3 : 2'd0;
    gd = (er != 0) ? d[gc*8 +: 8] : 8'h00;
    chk("ready", bus.req_ready_o, er);
    chk("enable", bus.rb_enable_o, |er);
    chk("rb_data", bus.rb_data_o, gd);
    chk("out_valid", bus.out_valid_o, exp_ov);
    if (exp_ov) begin
      chk("out_chan", bus.out_chan_o, exp_ch);
      chk("out_data", bus.out_data_o, exp_d);
    end
    exp_ov = 1'b0;
    if (er != 0) begin
      sbq.push_back({gc, gd});
      if (sbq.size() > 8) begin
        {exp_ch, exp_d} = sbq.pop_front();
        exp_ov = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask
  task automatic step(input logic [3:0] v, input logic [3:0] er);
    cyc(v, er, mkd(seq));
    seq = seq + 6'd1;
  endtask
  task automatic do_reset;
    rst_ni = 1'b0;
    bus.req_valid_i = '0;
    bus.req_data_i = '0;
`ifdef RB_ARB_FLUSH_EN
    bus.flush_i = 1'b0;
`endif
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    sbq.delete();
    exp_ov = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 16; i++) fair_tbl.push_back('{4'hF, 4'b0001 << (i % 4)});
    fair_tbl.push_back('{4'h0, 4'h0});
    mix_tbl.push_back('{4'b1010, 4'b0010});
    mix_tbl.push_back('{4'b1011, 4'b1000});
    mix_tbl.push_back('{4'b0110, 4'b0010});
    mix_tbl.push_back('{4'b0110, 4'b0100});
    mix_tbl.push_back('{4'b0000, 4'b0000});
    mix_tbl.push_back('{4'b0011, 4'b0001});
    mix_tbl.push_back('{4'b0001, 4'b0001});
    mix_tbl.push_back('{4'b1001, 4'b1000});
    mix_tbl.push_back('{4'b1111, 4'b0001});
    mix_tbl.push_back('{4'b1101, 4'b0100});
    mix_tbl.push_back('{4'b0101, 4'b0001});
    mix_tbl.push_back('{4'b1000, 4'b1000});
    mix_tbl.push_back('{4'b0000, 4'b0000});
    mix_tbl.push_back('{4'b0000, 4'b0000});
    exp_ov = 1'b0;
    rst_ni = 1'b0;
    bus.req_valid_i = 4'hF;
    bus.req_data_i = mkd(6'h3F);
`ifdef RB_ARB_FLUSH_EN
    bus.flush_i = 1'b0;
`endif
    // T1: reset state, then one blocked cycle while rb_rst_o drains
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_ready", bus.req_ready_o, 4'h0);
    chk("rst_enable", bus.rb_enable_o, 1'b0);
    chk("rst_out_valid", bus.out_valid_o, 1'b0);
    chk("rst_rb_rst", bus.rb_rst_o, 1'b1);
    chk("rst_rb_data", bus.rb_data_o, 8'h00);
    rst_ni = 1'b1;
    #4;
    chk("rel_rb_rst", bus.rb_rst_o, 1'b1);
    chk("rel_ready", bus.req_ready_o, 4'h0);
    @(posedge clk_i);
    #1;
    chk("rel2_rb_rst", bus.rb_rst_o, 1'b0);
    // T2: all valid, round robin fairness, first word returns after the 9th grant
    for (int i = 0; i < fair_tbl.size(); i++) begin
      if (i == 0) fw = mkd(seq) & 32'hFF;
      step(fair_tbl[i].v, fair_tbl[i].r);
      if (i == 8) begin
        chk("t2_first_valid", bus.out_valid_o, 1'b1);
        chk("t2_first_chan", bus.out_chan_o, 2'd0);
        chk("t2_first_data", bus.out_data_o, fw);
      end
    end
    // Mixed valid patterns, priority rotation
    do_reset;
    for (int i = 0; i < mix_tbl.size(); i++) step(mix_tbl[i].v, mix_tbl[i].r);
    // T3: only ch2, data 0x10..0x1F
    do_reset;
    for (int i = 0; i < 16; i++) begin
      cyc(4'b0100, 4'b0100, {8'h00, 8'(8'h10 + i), 16'h0000});
      if (i == 8) begin
        chk("t3_valid", bus.out_valid_o, 1'b1);
        chk("t3_chan", bus.out_chan_o, 2'd2);
        chk("t3_data", bus.out_data_o, 8'h10);
      end
    end
    cyc(4'h0, 4'h0, 32'h0);
    // T4: ch1 three grants, then ch3 with 20-cycle gaps
    do_reset;
    for (int i = 0; i < 3; i++) step(4'b0010, 4'b0010);
    for (int k = 0; k < 8; k++) begin
      step(4'b1000, 4'b1000);
      for (int g = 0; g < 20; g++) step(4'b0000, 4'b0000);
    end
`ifdef RB_ARB_FLUSH_EN
    // flush_i with no valid tag is ignored
    do_reset;
    bus.flush_i = 1'b1;
    cyc(4'h0, 4'h0, 32'h0);
    bus.flush_i = 1'b0;
    chk("idle_flush_busy", bus.busy_o, 1'b0);
    cyc(4'b0001, 4'b0001, 32'h11);
    // T5: three ch0 words then flush
    do_reset;
    for (int i = 0; i < 3; i++) cyc(4'b0001, 4'b0001, {24'h0, 8'(8'hA0 + i)});
    bus.req_valid_i = 4'h0;
    bus.flush_i = 1'b1;
    #4;
    chk("t5_pre_busy", bus.busy_o, 1'b0);
    @(posedge clk_i);
    #1;
    for (int j = 0; j < 10; j++) begin
      bus.req_valid_i = (j < 8) ? 4'hF : 4'h0;
      bus.flush_i = j < 8;
      #4;
      chk("t5_busy", bus.busy_o, j < 8);
      chk("t5_ready", bus.req_ready_o, 4'h0);
      chk("t5_enable", bus.rb_enable_o, j < 8);
      chk("t5_rb_data", bus.rb_data_o, 8'h00);
      chk("t5_out_valid", bus.out_valid_o, j >= 6 && j <= 8);
      if (j >= 6 && j <= 8) begin
        chk("t5_out_chan", bus.out_chan_o, 2'd0);
        chk("t5_out_data", bus.out_data_o, 8'(8'hA0 + j - 6));
      end
      @(posedge clk_i);
      #1;
    end
    bus.flush_i = 1'b0;
    // T6: reset during flush
    do_reset;
    for (int i = 0; i < 4; i++) cyc(4'b0001, 4'b0001, {24'h0, 8'(8'hB0 + i)});
    bus.req_valid_i = 4'h0;
    bus.flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.flush_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #4;
      chk("t6_busy", bus.busy_o, 1'b1);
      @(posedge clk_i);
      #1;
    end
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_busy", bus.busy_o, 1'b0);
    chk("t6_rst_enable", bus.rb_enable_o, 1'b0);
    chk("t6_rst_out_valid", bus.out_valid_o, 1'b0);
    chk("t6_rst_rb_rst", bus.rb_rst_o, 1'b1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    sbq.delete();
    exp_ov = 1'b0;
    for (int i = 0; i < 9; i++) step(4'b0001, 4'b0001);
    step(4'b0000, 4'b0000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
